// File: rtl/hazard_stall_controller_pkg.sv
// Shared definitions for the hazard/stall controller: MDU FSM encoding,
// the hardwired zero register and default MDU latencies.
package hazard_stall_controller_pkg;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    localparam logic [4:0] REG_ZERO         = 5'd0;
    localparam int         MULT_CYCLES_DEF  = 4;
    localparam int         DIV_CYCLES_DEF   = 32;
    localparam int         CNT_W_DEF        = 6;

endpackage

// File: rtl/hazard_stall_controller_mdu_sequencer.sv
// MDU launch/complete FSM: IDLE -> BUSY (N cycles) -> DONE (1 cycle) -> IDLE.
module hazard_stall_controller_mdu_sequencer
    import hazard_stall_controller_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       div,
    output mdu_state_e state,
    output logic       mdu_busy,
    output logic       mdu_done
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter holds remaining BUSY cycles minus one, so N=1 yields one BUSY cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MDU_IDLE: begin
                if (go) begin
                    state_d = MDU_BUSY;
                    cnt_d   = div ? DIV_LOAD : MULT_LOAD;
                end
            end
            MDU_BUSY: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = MDU_DONE;
            end
            MDU_DONE: state_d = MDU_IDLE;
            default: begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state    = state_q;
    assign mdu_busy = (state_q != MDU_IDLE);
    assign mdu_done = (state_q == MDU_DONE);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer: load-use stall, EX redirect flush and HI/LO
// stalls behind the multi-cycle MDU, with prioritised stall/flush outputs.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_uses_rt,
    input  logic [4:0] EX_rt,
    input  logic       EX_mem_rd,
    input  logic       EX_redirect,
    input  logic       ID_mdu_start,
    input  logic       ID_mdu_div,
    input  logic       ID_mdu_read,
    output logic       stall_pc,
    output logic       stall_IFID,
    output logic       bubble_IDEX,
    output logic       flush_IFID,
    output logic       mdu_go,
    output logic       mdu_busy,
    output logic       mdu_done
);

    mdu_state_e mdu_state;
    logic       seq_busy, seq_done;
    logic       load_use, mdu_haz;

    hazard_stall_controller_mdu_sequencer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .go       (mdu_go),
        .div      (ID_mdu_div),
        .state    (mdu_state),
        .mdu_busy (seq_busy),
        .mdu_done (seq_done)
    );

    assign load_use = EX_mem_rd && (EX_rt != REG_ZERO) &&
                      ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
    assign mdu_haz  = (ID_mdu_read || ID_mdu_start) && (mdu_state != MDU_IDLE);

    // A redirect squashes the ID instruction, so it must neither stall nor launch.
    always_comb begin
        stall_pc    = 1'b0;
        stall_IFID  = 1'b0;
        bubble_IDEX = 1'b0;
        flush_IFID  = 1'b0;
        mdu_go      = 1'b0;
        if (!rst) begin
            if (EX_redirect) begin
                flush_IFID  = 1'b1;
                bubble_IDEX = 1'b1;
            end else if (load_use || mdu_haz) begin
                stall_pc    = 1'b1;
                stall_IFID  = 1'b1;
                bubble_IDEX = 1'b1;
            end else if (ID_mdu_start) begin
                mdu_go = 1'b1;
            end
        end
    end

    assign mdu_busy = !rst && seq_busy;
    assign mdu_done = !rst && seq_done;

endmodule
